// File: rtl/aes_round_key_gen_pkg.sv
// Shared types, mode lookups, rcon helpers and the AES S-box for the key-expansion engine.
package aes_keygen_pkg;

  typedef enum logic [1:0] {
    KM_128 = 2'b00,
    KM_192 = 2'b01,
    KM_256 = 2'b10,
    KM_ILL = 2'b11
  } key_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXPAND,
    ST_DRAIN
  } kx_state_t;

  typedef struct packed {
    logic [127:0] data;
    logic [3:0]   idx;
    logic         last;
  } rk_entry_t;

  localparam logic [7:0] RCON_INIT = 8'h01;

  function automatic logic [3:0] nk_of(key_mode_t m);
    case (m)
      KM_192:  return 4'd6;
      KM_256:  return 4'd8;
      default: return 4'd4;
    endcase
  endfunction

  function automatic logic [3:0] nr_of(key_mode_t m);
    case (m)
      KM_192:  return 4'd12;
      KM_256:  return 4'd14;
      default: return 4'd10;
    endcase
  endfunction

  function automatic logic [7:0] xtime(logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

endpackage

// File: rtl/aes_round_key_gen_if.sv
// Request/round-key handshake bundle between the key register bank, the expander and the round datapath.
interface aes_round_key_gen_if;
  logic         start;
  logic [1:0]   key_mode;
  logic [255:0] key_in;
  logic         busy;
  logic         err;
  logic         rk_valid;
  logic         rk_ready;
  logic [127:0] rk_data;
  logic [3:0]   rk_index;
  logic         rk_last;

  modport master (
    output start, key_mode, key_in, rk_ready,
    input  busy, err, rk_valid, rk_data, rk_index, rk_last
  );

  modport slave (
    input  start, key_mode, key_in, rk_ready,
    output busy, err, rk_valid, rk_data, rk_index, rk_last
  );
endinterface

// File: rtl/aes_round_key_gen_sub_word.sv
// SubWord: four parallel S-box lookups on a 32-bit word, purely combinational.
module aes_sub_word
  import aes_keygen_pkg::*;
(
  input  logic [31:0] i_word,
  output logic [31:0] o_word
);
  assign o_word = {SBOX[i_word[31:24]], SBOX[i_word[23:16]], SBOX[i_word[15:8]], SBOX[i_word[7:0]]};
endmodule

// File: rtl/aes_round_key_gen.sv
// AES-128/192/256 key expander: one word per cycle, 128-bit round keys out through a small FIFO.
// AES-192 support is present only when AES_KEY192_EN is defined; otherwise key_mode 01 is rejected.
//
// state     | meaning
// ST_IDLE   | waiting for start; illegal modes pulse err
// ST_EXPAND | generating w[i], pushing every 4th word as a round key
// ST_DRAIN  | all words generated, waiting for the FIFO to empty
module aes_round_key_gen
  import aes_keygen_pkg::*;
#(
  parameter int OUT_DEPTH = 2
) (
  input logic                clk,
  input logic                n_rst,
  aes_round_key_gen_if.slave bus
);

  kx_state_t        r_state;
  logic [7:0][31:0] r_key;
  logic [31:0]      r_win [8];
  logic [5:0]       r_i;
  logic [3:0]       r_nk;
  logic [3:0]       r_nr;
  logic [7:0]       r_rcon;
  logic             r_busy;
  logic             r_err;
  rk_entry_t        r_fifo [OUT_DEPTH];
  logic [2:0]       r_cnt;

  logic [31:0] w_prev, w_far, w_sub_in, w_sub_out, w_t, w_new;
  logic [2:0]  w_kmod, w_wr_idx;
  logic        w_mod0, w_mod4, w_mode_ok, w_accept;
  logic        w_pop, w_full, w_gen, w_push, w_last_word;
  rk_entry_t   w_entry;

  always_comb begin
    case (key_mode_t'(bus.key_mode))
      KM_128, KM_256: w_mode_ok = 1'b1;
`ifdef AES_KEY192_EN
      KM_192:         w_mode_ok = 1'b1;
`endif
      default:        w_mode_ok = 1'b0;
    endcase
  end

  assign w_accept = (r_state == ST_IDLE) && bus.start && w_mode_ok;

  // w[i-Nk] sits at window depth Nk-1
  always_comb begin
    w_far = r_win[3];
    case (r_nk)
      4'd8:    w_far = r_win[7];
`ifdef AES_KEY192_EN
      4'd6:    w_far = r_win[5];
`endif
      default: w_far = r_win[3];
    endcase
  end

`ifdef AES_KEY192_EN
  logic [2:0] r_kcnt;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_kcnt <= '0;
    end else if (w_accept) begin
      r_kcnt <= '0;
    end else if (w_gen) begin
      r_kcnt <= ({1'b0, r_kcnt} == r_nk - 4'd1) ? 3'd0 : r_kcnt + 3'd1;
    end
  end

  assign w_kmod = r_kcnt;
`else
  assign w_kmod = (r_nk == 4'd8) ? r_i[2:0] : {1'b0, r_i[1:0]};
`endif

  assign w_prev   = r_win[0];
  assign w_mod0   = (w_kmod == 3'd0);
  assign w_mod4   = (r_nk == 4'd8) && (w_kmod == 3'd4);
  assign w_sub_in = w_mod0 ? {w_prev[23:0], w_prev[31:24]} : w_prev;

  aes_sub_word u_sub_word (
    .i_word (w_sub_in),
    .o_word (w_sub_out)
  );

  assign w_t   = w_mod0 ? (w_sub_out ^ {r_rcon, 24'h0}) : (w_mod4 ? w_sub_out : w_prev);
  assign w_new = (r_i < {2'b00, r_nk}) ? r_key[3'd7 - r_i[2:0]] : (w_far ^ w_t);

  assign w_pop       = (r_cnt != 3'd0) && bus.rk_ready;
  assign w_full      = (r_cnt == 3'(OUT_DEPTH));
  assign w_gen       = (r_state == ST_EXPAND) && !((r_i[1:0] == 2'b11) && w_full && !w_pop);
  assign w_push      = w_gen && (r_i[1:0] == 2'b11);
  assign w_last_word = (r_i == {r_nr, 2'b11});
  assign w_wr_idx    = w_pop ? r_cnt - 3'd1 : r_cnt;

  assign w_entry.data = {r_win[2], r_win[1], r_win[0], w_new};
  assign w_entry.idx  = r_i[5:2];
  assign w_entry.last = (r_i[5:2] == r_nr);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= ST_IDLE;
      r_key   <= '0;
      r_i     <= '0;
      r_nk    <= 4'd4;
      r_nr    <= 4'd10;
      r_rcon  <= RCON_INIT;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
      for (int k = 0; k < 8; k++) r_win[k] <= '0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state <= ST_EXPAND;
            r_busy  <= 1'b1;
            r_key   <= bus.key_in;
            r_i     <= '0;
            r_rcon  <= RCON_INIT;
            r_nk    <= nk_of(key_mode_t'(bus.key_mode));
            r_nr    <= nr_of(key_mode_t'(bus.key_mode));
          end else if (bus.start) begin
            r_err <= 1'b1;
          end
        end
        ST_EXPAND: begin
          if (w_gen) begin
            r_win[0] <= w_new;
            for (int k = 1; k < 8; k++) r_win[k] <= r_win[k-1];
            r_i <= r_i + 6'd1;
            if (w_mod0 && (r_i >= {2'b00, r_nk})) r_rcon <= xtime(r_rcon);
            if (w_push && w_last_word) r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // leave as soon as the final pop is taken so busy drops right after it
          if ((r_cnt == 3'd0) || ((r_cnt == 3'd1) && w_pop)) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Shift-down FIFO: head is always entry 0, so outputs come straight from registers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_cnt <= '0;
      for (int k = 0; k < OUT_DEPTH; k++) r_fifo[k] <= '0;
    end else begin
      r_cnt <= r_cnt + 3'(w_push) - 3'(w_pop);
      for (int k = 0; k < OUT_DEPTH; k++) begin
        if (w_push && (w_wr_idx == 3'(k))) begin
          r_fifo[k] <= w_entry;
        end else if (w_pop && (k < OUT_DEPTH - 1)) begin
          r_fifo[k] <= r_fifo[(k < OUT_DEPTH - 1) ? k + 1 : k];
        end
      end
    end
  end

  assign bus.busy     = r_busy;
  assign bus.err      = r_err;
  assign bus.rk_valid = (r_cnt != 3'd0);
  assign bus.rk_data  = r_fifo[0].data;
  assign bus.rk_index = r_fifo[0].idx;
  assign bus.rk_last  = r_fifo[0].last;

endmodule

// File: tb/tb_aes_round_key_gen.sv
// Self-checking bench for aes_round_key_gen; the AES-192 expectations follow AES_KEY192_EN.
module tb_aes_round_key_gen;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  aes_round_key_gen_if bus();

  aes_round_key_gen #(.OUT_DEPTH(2)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] R0_128  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] R10_128 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] R12_192 = 128'he98ba06f448c773c8ecc720401002202;
  localparam logic [127:0] R14_256 = 128'hfe4890d1e6188d0b046df344706c631e;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int start_cyc, first_cyc, last_cyc, last_pop_cyc, low_cyc;
  int got_cnt = 0;
  int err_cnt = 0;
  logic [7:0]   sb [256];
  logic [132:0] exp_q [$];
  logic [127:0] got_data [16];

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(logic [7:0] b, int k);
    logic [15:0] d;
    d = {b, b} << k;
    return d[15:8];
  endfunction

  // S-box from its definition: GF(2^8) inverse followed by the affine map
  function automatic void init_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endfunction

  function automatic logic [31:0] subw(logic [31:0] x);
    return {sb[x[31:24]], sb[x[23:16]], sb[x[15:8]], sb[x[7:0]]};
  endfunction

  function automatic void load_model(int nk, logic [255:0] key);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    int nr;
    nr = nk + 6;
    rc = 8'h01;
    exp_q.delete();
    for (int i = 0; i < 4 * (nr + 1); i++) begin
      if (i < nk) begin
        w[i] = key[255 - 32 * i -: 32];
      end else begin
        t = w[i-1];
        if (i % nk == 0) begin
          t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
          rc = gmul(rc, 8'h02);
        end else if (nk == 8 && i % nk == 4) begin
          t = subw(t);
        end
        w[i] = w[i-nk] ^ t;
      end
    end
    for (int r = 0; r <= nr; r++)
      exp_q.push_back({w[4*r], w[4*r+1], w[4*r+2], w[4*r+3], 4'(r), r == nr});
    got_cnt = 0;
    first_cyc = -1;
    last_cyc = -1;
    last_pop_cyc = -1;
  endfunction

  // Every cycle the head is valid it must match the model's next key
  always @(negedge clk) begin
    if (n_rst) begin
      if (bus.err) err_cnt++;
      if (bus.rk_valid) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_key: got index %0d with no key expected", bus.rk_index);
        end else begin
          check("rk_head", {bus.rk_data, bus.rk_index, bus.rk_last}, exp_q[0]);
          if (bus.rk_index == 4'd0 && first_cyc < 0) first_cyc = cyc;
          if (bus.rk_last && last_cyc < 0) last_cyc = cyc;
          if (bus.rk_ready) begin
            got_data[bus.rk_index] = bus.rk_data;
            got_cnt++;
            last_pop_cyc = cyc;
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  task automatic start_job(input logic [1:0] mode, input logic [255:0] key);
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.key_mode = mode;
    bus.key_in = key;
    @(posedge clk); #1;
    start_cyc = cyc;
    bus.start = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    low_cyc = -1;
    while (n < budget) begin
      @(negedge clk);
      if (!bus.busy) begin
        low_cyc = cyc;
        break;
      end
      n++;
    end
    if (low_cyc < 0) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: busy still high after %0d cycles", name, budget);
    end
  endtask

  task automatic run_full(input string name, input logic [1:0] mode, input int nk, input logic [255:0] key,
                          input logic [127:0] last_key);
    int nr;
    nr = nk + 6;
    load_model(nk, key);
    start_job(mode, key);
    check({name, "_busy_up"}, 256'(bus.busy), 256'd1);
    wait_idle(name, 300);
    check({name, "_key_count"}, 256'(got_cnt), 256'(nr + 1));
    check({name, "_last_key"}, 256'(got_data[nr]), 256'(last_key));
    check({name, "_r0_latency"}, 256'(first_cyc - start_cyc), 256'd4);
    check({name, "_last_latency"}, 256'(last_cyc - start_cyc), 256'(4 * nr + 4));
    check({name, "_busy_fall"}, 256'(low_cyc - last_pop_cyc), 256'd1);
  endtask

  initial begin
    int e0;
    bus.start = 1'b0;
    bus.key_mode = 2'b00;
    bus.key_in = '0;
    bus.rk_ready = 1'b1;
    init_sbox();
    check("model_sbox_53", 256'(sb[8'h53]), 256'h00ed);
    check("model_sbox_00", 256'(sb[8'h00]), 256'h0063);

    #2;
    check("reset_outputs", {bus.busy, bus.err, bus.rk_valid, bus.rk_data, bus.rk_index, bus.rk_last}, '0);
    repeat (3) @(posedge clk);
    #1 n_rst = 1'b1;

    // AES-128 unstalled
    run_full("aes128", 2'b00, 4, K128, R10_128);
    check("aes128_round0", 256'(got_data[0]), 256'(R0_128));

    // AES-192
`ifdef AES_KEY192_EN
    run_full("aes192", 2'b01, 6, K192, R12_192);
`else
    exp_q.delete();
    got_cnt = 0;
    e0 = err_cnt;
    start_job(2'b01, K192);
    @(negedge clk);
    check("aes192_off_err", 256'(bus.err), 256'd1);
    check("aes192_off_busy", 256'(bus.busy), 256'd0);
    repeat (20) @(negedge clk);
    check("aes192_off_err_count", 256'(err_cnt - e0), 256'd1);
    check("aes192_off_no_keys", 256'(got_cnt), 256'd0);
`endif

    // AES-256 with an ignored start while busy
    load_model(8, K256);
    e0 = err_cnt;
    start_job(2'b10, K256);
    repeat (10) @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.key_mode = 2'b00;
    bus.key_in = K128;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_idle("aes256", 300);
    check("aes256_key_count", 256'(got_cnt), 256'd15);
    check("aes256_last_key", 256'(got_data[14]), 256'(R14_256));
    check("aes256_last_latency", 256'(last_cyc - start_cyc), 256'd60);
    check("busy_start_no_err", 256'(err_cnt - e0), 256'd0);

    // Backpressure mid AES-128
    load_model(4, K128);
    start_job(2'b00, K128);
    repeat (10) @(posedge clk);
    #1 bus.rk_ready = 1'b0;
    repeat (30) @(posedge clk);
    @(negedge clk);
    check("stall_busy_valid", {bus.busy, bus.rk_valid}, 256'b11);
    @(posedge clk); #1 bus.rk_ready = 1'b1;
    wait_idle("stall", 300);
    check("stall_key_count", 256'(got_cnt), 256'd11);
    check("stall_last_key", 256'(got_data[10]), 256'(R10_128));
    check("stall_queue_empty", 256'(exp_q.size()), 256'd0);

    // Illegal mode in IDLE
    e0 = err_cnt;
    start_job(2'b11, K256);
    @(negedge clk);
    check("illegal_err", {bus.err, bus.busy}, 256'b10);
    @(negedge clk);
    check("illegal_err_drop", {bus.err, bus.busy}, 256'b00);
    check("illegal_err_count", 256'(err_cnt - e0), 256'd1);

    // Reset mid AES-256, then a fresh AES-128
    load_model(8, K256);
    start_job(2'b10, K256);
    repeat (20) @(posedge clk);
    #1 n_rst = 1'b0;
    exp_q.delete();
    #1;
    check("midreset_outputs", {bus.busy, bus.err, bus.rk_valid, bus.rk_data, bus.rk_index, bus.rk_last}, '0);
    repeat (2) @(posedge clk);
    #1 n_rst = 1'b1;
    run_full("after_reset", 2'b00, 4, K128, R10_128);
    check("after_reset_round0", 256'(got_data[0]), 256'(R0_128));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
